serial_adder_fsm: RTL
=====================

// Module: serial_adder_fsm
// PURPOSE
//  Parametrised bit-serial adder: one full-adder cell plus a carry flip-flop adds two W-bit operands LSB-first over W clocks.
//  Successor to the single-bit combinational full adder.
//  Start/busy/done handshake; sits between register-file style operand sources and result sinks where area beats latency.
// PARAMETERS
//  W      8   operand/result width in bits, W >= 1
//  CNT_W  $clog2(W+1)  bit-counter width (derived localparam, not overridden)
// PORTS
//  clk    in   1  single clock, all state on rising edge
//  rst    in   1  synchronous reset, active-high
//  start  in   1  request; sampled only in IDLE
//  a      in   W  operand A, sampled on accepted start
//  b      in   W  operand B, sampled on accepted start
//  cin    in   1  carry-in, sampled on accepted start
//  sum    out  W  registered result, holds until next completion
//  cout   out  1  registered carry-out of MSB
//  busy   out  1  high while in RUN
//  done   out  1  one-cycle pulse: sum/cout just updated
// BEHAVIOUR
//  One clock. Reset is synchronous and active-high.
//  Reset (rst=1 at an edge): state=IDLE, sum=0, cout=0, busy=0, done=0, shift regs/carry/count=0.
//    Takes priority over all other activity, including mid-RUN: the operation is aborted and no done is issued.
//  FSM states:
//    IDLE: start=1 at edge k -> a_sr<=a, b_sr<=b, carry<=cin, sum_sr<=0, count<=0, state<=RUN, busy<=1.
//    RUN: each edge -> s = a_sr[0]^b_sr[0]^carry; carry <= majority(a_sr[0],b_sr[0],carry).
//      Shift a_sr/b_sr right; shift s into sum_sr MSB; count<=count+1.
//    RUN, edge where count==W-1 (edge k+W) -> sum<={s,sum_sr[W-1:1]}, cout<=carry_next, done<=1, busy<=0, state<=IDLE.
//  Latency: start sampled at edge k -> done high in the cycle after edge k+W (W clocks). Throughput: one op per W+1 clocks min.
//  done is high exactly one cycle; cleared at the next edge unconditionally.
//  start while busy: ignored, with no queueing. Operand changes during RUN have no effect.
//  start in the cycle done is high: accepted (state already IDLE).
//  W=1: one RUN edge; equivalent to a registered full adder.
//  Wrap-around: result is modulo 2^W; overflow is reported only via cout (unsigned).
//  sum/cout never change except at reset or completion.
// CONFIGURATION
//  SERIAL_ADDER_SUB_EN defined:
//    Extra input port sub (1 bit), sampled with start.
//    sub=1 -> b_sr<=~b, carry<=1 (cin ignored); result = a-b mod 2^W; cout=1 means no borrow (a>=b).
//    sub=0 -> identical to plain add.
//  SERIAL_ADDER_SUB_EN undefined: no sub port, add only; port list is exactly as above.
// TESTING
//  (W=8 unless noted; check done timing against the start edge in every case)
//  1. rst=1 2 cycles -> sum=00, cout=0, busy=0, done=0. Then a=FF,b=01,cin=0,start pulse -> busy 8 cycles; done pulse; sum=00,cout=1.
//  2. a=5A,b=A5,cin=1 -> sum=00,cout=1. Then a=12,b=34,cin=0 -> sum=46,cout=0. sum holds 46 until next done.
//  3. W=1 build: all 8 {a,b,cin} combos -> {cout,sum} = 00,01,01,10,01,10,10,11 in order 000..111, done 1 clk after start.
//  4. start held high with a=01,b=01, then a=FF mid-RUN -> only first op runs (sum=02).
//     Back-to-back: start asserted in the done cycle is accepted.
//  5. rst=1 at RUN cycle 4 of a=FF+b=FF -> no done, sum/cout=0, busy=0 next cycle. Next op 03+04 -> sum=07.
//  6. SERIAL_ADDER_SUB_EN: sub=1,a=10,b=01 -> sum=0F,cout=1; sub=1,a=01,b=02 -> sum=FF,cout=0; sub=0 -> add results as test 2.

Source files
------------

// File: rtl/serial_adder_fsm.sv
// serial_adder_fsm: bit-serial W-bit adder (LSB first, one full-adder cell + carry flop) with start/busy/done handshake; optional subtract via SERIAL_ADDER_SUB_EN (adds port sub). Ports: clk, rst, start, a, b, cin, [sub], sum, cout, busy, done.
module serial_adder_fsm #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy,
  output logic         done
);
  localparam int CNT_W = $clog2(W + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [W-1:0] a_sr, b_sr, sum_sr, sum_nx;
  logic [CNT_W-1:0] count;
  logic carry, s, carry_nx, sub_i;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif
  assign s        = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_nx = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
  assign sum_nx   = W'({s, sum_sr} >> 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_sr   <= a;
          b_sr   <= sub_i ? ~b : b;
          carry  <= sub_i | cin;
          sum_sr <= '0;
          count  <= '0;
          busy   <= 1'b1;
          state  <= RUN;
        end
      end else begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        carry  <= carry_nx;
        sum_sr <= sum_nx;
        count  <= count + CNT_W'(1);
        if (count == CNT_W'(W - 1)) begin
          sum   <= sum_nx;
          cout  <= carry_nx;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule
